// File: rtl/id_ex_ctrl_pipe_pkg.sv
// Shared decode constants and the ID/EX control bundle layout.
// Opcodes are the 6-bit MIPS-style major opcode values.
package id_ex_ctrl_pipe_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BGE  = 6'b000001;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_BGT  = 6'b000111;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   // one-hot branch vector {bgt,bge,bne,beq}
   localparam int BR_BEQ = 0;
   localparam int BR_BNE = 1;
   localparam int BR_BGE = 2;
   localparam int BR_BGT = 3;

   localparam int ALU_SLTI = 0;
   localparam int ALU_R    = 1;
   localparam int ALU_BR   = 2;
   localparam int ALU_BASE_W = 3;

   typedef struct packed {
      logic                  regwrite;
      logic [ALU_BASE_W-1:0] alu_op;
      logic                  alusrc;
      logic                  regdst;
      logic [3:0]            br;
      logic                  memread;
      logic                  memwrite;
      logic                  memtoreg;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_ctrl_pipe_if.sv
// ID-side request and EX-side control bundle between IF/ID, the control pipe and EX.
interface id_ex_ctrl_pipe_if #(
   parameter int OP_W        = 6,
   parameter int RA_W        = 5,
   parameter int ALU_OP_W    = 3,
   parameter int STALL_CNT_W = 16
);
   logic                   id_valid_i;
   logic [OP_W-1:0]        instr_op_i;
   logic [RA_W-1:0]        rs_i;
   logic [RA_W-1:0]        rt_i;
   logic [RA_W-1:0]        rd_i;
   logic                   flush_i;
   logic                   hold_i;
   logic                   stall_o;
   logic                   ex_valid_o;
   logic                   ex_regwrite_o;
   logic [ALU_OP_W-1:0]    ex_alu_op_o;
   logic                   ex_alusrc_o;
   logic                   ex_regdst_o;
   logic [3:0]             ex_br_o;
   logic                   ex_memread_o;
   logic                   ex_memwrite_o;
   logic                   ex_memtoreg_o;
   logic [RA_W-1:0]        ex_wreg_o;
   logic                   ex_illegal_o;
   logic [STALL_CNT_W-1:0] stall_cnt_o;

   // master: the ID stage / pipeline glue driving instructions in
   modport master (
      output id_valid_i, instr_op_i, rs_i, rt_i, rd_i, flush_i, hold_i,
      input  stall_o, ex_valid_o, ex_regwrite_o, ex_alu_op_o, ex_alusrc_o,
             ex_regdst_o, ex_br_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o,
             ex_wreg_o, ex_illegal_o, stall_cnt_o
   );

   // slave: the control pipe itself
   modport slave (
      input  id_valid_i, instr_op_i, rs_i, rt_i, rd_i, flush_i, hold_i,
      output stall_o, ex_valid_o, ex_regwrite_o, ex_alu_op_o, ex_alusrc_o,
             ex_regdst_o, ex_br_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o,
             ex_wreg_o, ex_illegal_o, stall_cnt_o
   );
endinterface

// File: rtl/id_ex_ctrl_pipe_decode.sv
// Combinational main decoder: opcode -> control bundle, illegal flag, rt-usage flag.
module mips_ctrl_decode
   import id_ex_ctrl_pipe_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] op,
   output ctrl_t           ctrl,
   output logic            illegal,
   output logic            uses_rt
);

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      uses_rt = 1'b0;
      case (op)
         OP_W'(OP_R): begin
            ctrl.regdst        = 1'b1;
            ctrl.regwrite      = 1'b1;
            ctrl.alu_op[ALU_R] = 1'b1;
            uses_rt            = 1'b1;
         end
         OP_W'(OP_ADDI): begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         OP_W'(OP_SLTI): begin
            ctrl.alusrc           = 1'b1;
            ctrl.regwrite         = 1'b1;
            ctrl.alu_op[ALU_SLTI] = 1'b1;
         end
         OP_W'(OP_BEQ): begin
            ctrl.br[BR_BEQ]     = 1'b1;
            ctrl.alu_op[ALU_BR] = 1'b1;
            uses_rt             = 1'b1;
         end
         OP_W'(OP_BNE): begin
            ctrl.br[BR_BNE]     = 1'b1;
            ctrl.alu_op[ALU_BR] = 1'b1;
            uses_rt             = 1'b1;
         end
         OP_W'(OP_BGE): begin
            ctrl.br[BR_BGE]     = 1'b1;
            ctrl.alu_op[ALU_BR] = 1'b1;
            uses_rt             = 1'b1;
         end
         OP_W'(OP_BGT): begin
            ctrl.br[BR_BGT]     = 1'b1;
            ctrl.alu_op[ALU_BR] = 1'b1;
            uses_rt             = 1'b1;
         end
         OP_W'(OP_LW): begin
            ctrl.alusrc   = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.memread  = 1'b1;
            ctrl.memtoreg = 1'b1;
         end
         OP_W'(OP_SW): begin
            ctrl.alusrc   = 1'b1;
            ctrl.memwrite = 1'b1;
            uses_rt       = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// ID/EX control stage: registers decoded controls, detects load-use hazards,
// inserts bubbles on stall/flush and counts load-use bubbles (saturating).
module id_ex_ctrl_pipe
   import id_ex_ctrl_pipe_pkg::*;
#(
   parameter int OP_W        = 6,
   parameter int RA_W        = 5,
   parameter int ALU_OP_W    = 3,
   parameter bit HAZARD_EN   = 1'b1,
   parameter int STALL_CNT_W = 16
) (
   input logic clk_i,
   input logic rst_i,
   id_ex_ctrl_pipe_if.slave bus
);

   ctrl_t                  dec_ctrl;
   logic                   dec_illegal;
   logic                   dec_uses_rt;
   ctrl_t                  ex_ctrl;
   logic                   ex_valid;
   logic                   ex_illegal;
   logic [RA_W-1:0]        ex_wreg;
   logic [RA_W-1:0]        dec_wreg;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic                   stall;

   mips_ctrl_decode #(.OP_W(OP_W)) u_dec (
      .op      (bus.instr_op_i),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal),
      .uses_rt (dec_uses_rt)
   );

   assign dec_wreg = dec_ctrl.regwrite ? (dec_ctrl.regdst ? bus.rd_i : bus.rt_i) : '0;

   // Only a load already sitting in ID/EX can create a hazard; a bubble never does.
   generate
      if (HAZARD_EN) begin : g_hazard
         assign stall = bus.id_valid_i & ex_valid & ex_ctrl.memread & (ex_wreg != '0) &
                        ((ex_wreg == bus.rs_i) | (dec_uses_rt & (ex_wreg == bus.rt_i)));
      end else begin : g_no_hazard
         assign stall = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i || bus.flush_i) begin
         ex_valid   <= 1'b0;
         ex_ctrl    <= '0;
         ex_illegal <= 1'b0;
         ex_wreg    <= '0;
      end else if (bus.hold_i) begin
         ex_valid   <= ex_valid;
         ex_ctrl    <= ex_ctrl;
         ex_illegal <= ex_illegal;
         ex_wreg    <= ex_wreg;
      end else if (stall) begin
         ex_valid   <= 1'b0;
         ex_ctrl    <= '0;
         ex_illegal <= 1'b0;
         ex_wreg    <= '0;
      end else begin
         ex_valid   <= bus.id_valid_i;
         ex_ctrl    <= bus.id_valid_i ? dec_ctrl : '0;
         ex_illegal <= bus.id_valid_i & dec_illegal;
         ex_wreg    <= bus.id_valid_i ? dec_wreg : '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         stall_cnt <= '0;
      else if (stall && !bus.flush_i && !bus.hold_i && (stall_cnt != {STALL_CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign bus.stall_o       = stall;
   assign bus.ex_valid_o    = ex_valid;
   assign bus.ex_regwrite_o = ex_ctrl.regwrite;
   assign bus.ex_alu_op_o   = ALU_OP_W'(ex_ctrl.alu_op);
   assign bus.ex_alusrc_o   = ex_ctrl.alusrc;
   assign bus.ex_regdst_o   = ex_ctrl.regdst;
   assign bus.ex_br_o       = ex_ctrl.br;
   assign bus.ex_memread_o  = ex_ctrl.memread;
   assign bus.ex_memwrite_o = ex_ctrl.memwrite;
   assign bus.ex_memtoreg_o = ex_ctrl.memtoreg;
   assign bus.ex_wreg_o     = ex_wreg;
   assign bus.ex_illegal_o  = ex_illegal;
   assign bus.stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Directed bench for id_ex_ctrl_pipe: a default instance plus a 2-bit-counter instance
// fed identical stimulus for the saturation case.
module tb_id_ex_ctrl_pipe;
   logic clk = 1'b0;
   logic rst;
   logic id_valid, flush, hold;
   logic [5:0] op;
   logic [4:0] rs, rt, rd;
   int ntests = 0;
   int nfail  = 0;

   always #5 clk = ~clk;

   id_ex_ctrl_pipe_if b_if ();
   id_ex_ctrl_pipe_if #(.STALL_CNT_W(2)) s_if ();

   assign b_if.id_valid_i = id_valid;  assign s_if.id_valid_i = id_valid;
   assign b_if.instr_op_i = op;        assign s_if.instr_op_i = op;
   assign b_if.rs_i = rs;              assign s_if.rs_i = rs;
   assign b_if.rt_i = rt;              assign s_if.rt_i = rt;
   assign b_if.rd_i = rd;              assign s_if.rd_i = rd;
   assign b_if.flush_i = flush;        assign s_if.flush_i = flush;
   assign b_if.hold_i = hold;          assign s_if.hold_i = hold;

   id_ex_ctrl_pipe u_dut (.clk_i(clk), .rst_i(rst), .bus(b_if));
   id_ex_ctrl_pipe #(.STALL_CNT_W(2)) u_sat (.clk_i(clk), .rst_i(rst), .bus(s_if));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
      id_valid = v; op = o; rs = s; rt = t; rd = d;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; hold = 1'b0;
      drive(1'b1, 6'b100011, 5'd5, 5'd5, 5'd0);
      step(); step();
      ntests++; if (b_if.ex_valid_o !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %0b want 0", b_if.ex_valid_o); end
      ntests++; if ({b_if.ex_regwrite_o, b_if.ex_memread_o, b_if.ex_alusrc_o, b_if.ex_memtoreg_o} !== 4'b0) begin nfail++; $display("FAIL reset_ctrl: got %b want 0000", {b_if.ex_regwrite_o, b_if.ex_memread_o, b_if.ex_alusrc_o, b_if.ex_memtoreg_o}); end
      ntests++; if (b_if.ex_wreg_o !== 5'd0) begin nfail++; $display("FAIL reset_wreg: got %0d want 0", b_if.ex_wreg_o); end
      ntests++; if (b_if.stall_cnt_o !== 16'd0) begin nfail++; $display("FAIL reset_cnt: got %0d want 0", b_if.stall_cnt_o); end
      ntests++; if (b_if.stall_o !== 1'b0) begin nfail++; $display("FAIL reset_stall: got %0b want 0", b_if.stall_o); end
      drive(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0);
      rst = 1'b0;
      step();
   endtask

   task automatic test_decode();
      drive(1'b1, 6'b001000, 5'd1, 5'd7, 5'd3);   // addi
      step();
      ntests++; if ({b_if.ex_valid_o, b_if.ex_regwrite_o, b_if.ex_alusrc_o, b_if.ex_regdst_o} !== 4'b1110) begin nfail++; $display("FAIL addi_ctrl: got %b want 1110", {b_if.ex_valid_o, b_if.ex_regwrite_o, b_if.ex_alusrc_o, b_if.ex_regdst_o}); end
      ntests++; if (b_if.ex_alu_op_o !== 3'b000) begin nfail++; $display("FAIL addi_alu: got %b want 000", b_if.ex_alu_op_o); end
      ntests++; if (b_if.ex_wreg_o !== 5'd7) begin nfail++; $display("FAIL addi_wreg: got %0d want 7", b_if.ex_wreg_o); end
      drive(1'b1, 6'b000000, 5'd4, 5'd2, 5'd9);   // R
      step();
      ntests++; if ({b_if.ex_regdst_o, b_if.ex_regwrite_o, b_if.ex_alusrc_o} !== 3'b110) begin nfail++; $display("FAIL r_ctrl: got %b want 110", {b_if.ex_regdst_o, b_if.ex_regwrite_o, b_if.ex_alusrc_o}); end
      ntests++; if (b_if.ex_alu_op_o !== 3'b010) begin nfail++; $display("FAIL r_alu: got %b want 010", b_if.ex_alu_op_o); end
      ntests++; if (b_if.ex_wreg_o !== 5'd9) begin nfail++; $display("FAIL r_wreg: got %0d want 9", b_if.ex_wreg_o); end
      drive(1'b1, 6'b000111, 5'd4, 5'd2, 5'd9);   // bgt
      step();
      ntests++; if (b_if.ex_br_o !== 4'b1000) begin nfail++; $display("FAIL bgt_br: got %b want 1000", b_if.ex_br_o); end
      ntests++; if (b_if.ex_alu_op_o !== 3'b100) begin nfail++; $display("FAIL bgt_alu: got %b want 100", b_if.ex_alu_op_o); end
      ntests++; if ({b_if.ex_wreg_o, b_if.ex_regwrite_o} !== 6'd0) begin nfail++; $display("FAIL bgt_wreg: got %0d/%0b want 0/0", b_if.ex_wreg_o, b_if.ex_regwrite_o); end
      drive(1'b1, 6'b000001, 5'd4, 5'd2, 5'd9);   // bge
      step();
      ntests++; if (b_if.ex_br_o !== 4'b0100) begin nfail++; $display("FAIL bge_br: got %b want 0100", b_if.ex_br_o); end
      drive(1'b1, 6'b001010, 5'd4, 5'd2, 5'd9);   // slti
      step();
      ntests++; if ({b_if.ex_alu_op_o, b_if.ex_alusrc_o, b_if.ex_wreg_o} !== {3'b001, 1'b1, 5'd2}) begin nfail++; $display("FAIL slti: got %b/%b/%0d want 001/1/2", b_if.ex_alu_op_o, b_if.ex_alusrc_o, b_if.ex_wreg_o); end
      drive(1'b1, 6'b100011, 5'd1, 5'd6, 5'd9);   // lw
      step();
      ntests++; if ({b_if.ex_memread_o, b_if.ex_memtoreg_o, b_if.ex_regwrite_o, b_if.ex_wreg_o} !== {3'b111, 5'd6}) begin nfail++; $display("FAIL lw_ctrl: got %b/%0d want 111/6", {b_if.ex_memread_o, b_if.ex_memtoreg_o, b_if.ex_regwrite_o}, b_if.ex_wreg_o); end
      drive(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0);
      step();
   endtask

   task automatic test_load_use();
      drive(1'b1, 6'b100011, 5'd1, 5'd5, 5'd0);   // lw rt=5
      step();
      drive(1'b1, 6'b000000, 5'd5, 5'd6, 5'd8);   // add rs=5
      ntests++; if (b_if.stall_o !== 1'b1) begin nfail++; $display("FAIL lu_stall: got %0b want 1", b_if.stall_o); end
      step();
      ntests++; if (b_if.ex_valid_o !== 1'b0) begin nfail++; $display("FAIL lu_bubble: got %0b want 0", b_if.ex_valid_o); end
      ntests++; if (b_if.stall_cnt_o !== 16'd1) begin nfail++; $display("FAIL lu_cnt: got %0d want 1", b_if.stall_cnt_o); end
      ntests++; if (b_if.stall_o !== 1'b0) begin nfail++; $display("FAIL lu_stall_drop: got %0b want 0", b_if.stall_o); end
      step();
      ntests++; if ({b_if.ex_valid_o, b_if.ex_regdst_o, b_if.ex_wreg_o} !== {2'b11, 5'd8}) begin nfail++; $display("FAIL lu_add_load: got %b/%0d want 11/8", {b_if.ex_valid_o, b_if.ex_regdst_o}, b_if.ex_wreg_o); end
      drive(1'b1, 6'b100011, 5'd1, 5'd0, 5'd0);   // lw rt=0
      step();
      drive(1'b1, 6'b000000, 5'd0, 5'd0, 5'd8);
      ntests++; if (b_if.stall_o !== 1'b0) begin nfail++; $display("FAIL lu_r0_stall: got %0b want 0", b_if.stall_o); end
      step();
      ntests++; if ({b_if.ex_valid_o, b_if.stall_cnt_o} !== {1'b1, 16'd1}) begin nfail++; $display("FAIL lu_r0_load: got %0b/%0d want 1/1", b_if.ex_valid_o, b_if.stall_cnt_o); end
      drive(1'b1, 6'b100011, 5'd1, 5'd5, 5'd0);   // lw rt=5
      step();
      drive(1'b1, 6'b001000, 5'd1, 5'd5, 5'd0);   // addi rt=5, rt not read
      ntests++; if (b_if.stall_o !== 1'b0) begin nfail++; $display("FAIL lu_addi_stall: got %0b want 0", b_if.stall_o); end
      step();
      ntests++; if ({b_if.ex_valid_o, b_if.ex_alusrc_o, b_if.ex_wreg_o} !== {2'b11, 5'd5}) begin nfail++; $display("FAIL lu_addi_load: got %b/%0d want 11/5", {b_if.ex_valid_o, b_if.ex_alusrc_o}, b_if.ex_wreg_o); end
      drive(1'b1, 6'b100011, 5'd1, 5'd5, 5'd0);   // lw rt=5, then sw reading rt=5
      step();
      drive(1'b1, 6'b101011, 5'd2, 5'd5, 5'd0);
      ntests++; if (b_if.stall_o !== 1'b1) begin nfail++; $display("FAIL lu_sw_stall: got %0b want 1", b_if.stall_o); end
      step(); step();
      ntests++; if ({b_if.ex_memwrite_o, b_if.stall_cnt_o} !== {1'b1, 16'd2}) begin nfail++; $display("FAIL lu_sw_load: got %0b/%0d want 1/2", b_if.ex_memwrite_o, b_if.stall_cnt_o); end
      drive(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0);
      step();
   endtask

   task automatic test_flush_hold();
      flush = 1'b1; hold = 1'b1;
      drive(1'b1, 6'b101011, 5'd1, 5'd2, 5'd0);   // sw
      step();
      ntests++; if ({b_if.ex_valid_o, b_if.ex_memwrite_o} !== 2'b00) begin nfail++; $display("FAIL flush_over_hold: got %b want 00", {b_if.ex_valid_o, b_if.ex_memwrite_o}); end
      flush = 1'b0; hold = 1'b0;
      drive(1'b1, 6'b100011, 5'd1, 5'd5, 5'd0);   // lw rt=5
      step();
      hold = 1'b1;
      drive(1'b1, 6'b000000, 5'd5, 5'd6, 5'd8);
      for (int i = 0; i < 3; i++) begin
         step();
         ntests++; if ({b_if.ex_valid_o, b_if.ex_memread_o, b_if.ex_wreg_o} !== {2'b11, 5'd5}) begin nfail++; $display("FAIL hold_frozen[%0d]: got %b/%0d want 11/5", i, {b_if.ex_valid_o, b_if.ex_memread_o}, b_if.ex_wreg_o); end
         ntests++; if ({b_if.stall_o, b_if.stall_cnt_o} !== {1'b1, 16'd2}) begin nfail++; $display("FAIL hold_cnt[%0d]: got %0b/%0d want 1/2", i, b_if.stall_o, b_if.stall_cnt_o); end
      end
      hold = 1'b0;
      step();
      ntests++; if ({b_if.ex_valid_o, b_if.stall_cnt_o} !== {1'b0, 16'd3}) begin nfail++; $display("FAIL hold_release: got %0b/%0d want 0/3", b_if.ex_valid_o, b_if.stall_cnt_o); end
      drive(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0);
      step();
   endtask

   task automatic test_illegal();
      drive(1'b1, 6'b111111, 5'd1, 5'd2, 5'd3);
      step();
      ntests++; if ({b_if.ex_valid_o, b_if.ex_illegal_o, b_if.ex_regwrite_o, b_if.ex_memwrite_o} !== 4'b1100) begin nfail++; $display("FAIL illegal_valid: got %b want 1100", {b_if.ex_valid_o, b_if.ex_illegal_o, b_if.ex_regwrite_o, b_if.ex_memwrite_o}); end
      drive(1'b0, 6'b111111, 5'd1, 5'd2, 5'd3);
      step();
      ntests++; if ({b_if.ex_valid_o, b_if.ex_illegal_o} !== 2'b00) begin nfail++; $display("FAIL illegal_invalid: got %b want 00", {b_if.ex_valid_o, b_if.ex_illegal_o}); end
   endtask

   task automatic test_saturation();
      drive(1'b1, 6'b100011, 5'd1, 5'd5, 5'd0);
      step();
      drive(1'b1, 6'b000000, 5'd5, 5'd6, 5'd8);   // stall pending, then reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      ntests++; if ({b_if.ex_valid_o, b_if.stall_o, b_if.stall_cnt_o} !== {2'b00, 16'd0}) begin nfail++; $display("FAIL reset_mid_stall: got %b/%0d want 00/0", {b_if.ex_valid_o, b_if.stall_o}, b_if.stall_cnt_o); end
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, 6'b100011, 5'd1, 5'd5, 5'd0);
         step();
         drive(1'b1, 6'b000000, 5'd5, 5'd6, 5'd8);
         step(); step();
         ntests++; if (s_if.stall_cnt_o !== ((k > 3) ? 2'd3 : 2'(k))) begin nfail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, s_if.stall_cnt_o, (k > 3) ? 3 : k); end
         ntests++; if (b_if.stall_cnt_o !== 16'(k)) begin nfail++; $display("FAIL wide_cnt[%0d]: got %0d want %0d", k, b_if.stall_cnt_o, k); end
      end
      drive(1'b0, 6'b000000, 5'd0, 5'd0, 5'd0);
      step();
   endtask

   initial begin
      test_reset();
      test_decode();
      test_load_use();
      test_flush_hold();
      test_illegal();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
